bus_demux1_4_reg: RTL
=====================

// Module: bus_demux1_4_reg
//
// PURPOSE
//   Registered 1-to-4 bus distributor: the steering counterpart of the 4:1 bus mux.
//   It accepts one word per cycle on a valid/ready input, steered by a 2-bit destination
//   select, into one of four single-entry output holding registers.
//   Each output has its own valid/ready handshake.
//   It sits where one producer (e.g. a decode or writeback stage) fans out to four consumers.
//
// PARAMETERS
//   WIDTH  64  data width of the input word and of each output channel
//
// PORTS
//   clk        input   1           clock; all state updates on rising edge
//   reset      input   1           synchronous, active-low reset (0 = reset)
//   in_valid   input   1           input word present
//   in_ready   output  1           block can accept the word this cycle
//   in_sel     input   2           destination channel index 0..3
//   in_data    input   WIDTH       input word
//   out_valid  output  4           per-channel holding register full
//   out_ready  input   4           per-channel consumer takes word this cycle
//   out_data   output  [3:0][WIDTH]  per-channel held word
//   pending    output  3           number of full channels, 0..4
//
// BEHAVIOUR
//   - Reset (reset==0 at clk edge):
//     - out_valid=4'b0000, all out_data=0, pending=0.
//     - Any in-flight or simultaneous transfer is discarded.
//     - in_ready=0 while reset==0.
//   - in_ready (combinational) = reset & (~out_valid[in_sel] | out_ready[in_sel]).
//     - Depends only on the selected channel; other channels never stall the input.
//   - Accept = in_valid & in_ready.
//     - Next cycle: out_data[in_sel]=in_data and out_valid[in_sel]=1.
//     - Latency is 1 cycle input to output.
//   - Drain of channel i = out_valid[i] & out_ready[i].
//     - If channel i is not loaded in the same cycle, out_valid[i] clears next cycle.
//     - out_data[i] keeps its last value after draining; it is not zeroed.
//   - Simultaneous drain and load of the same channel:
//     - out_valid[i] stays 1 and out_data[i] takes the new word.
//     - No bubble, no loss.
//   - Simultaneous load of channel j and drain of channel i (i!=j): both happen independently.
//   - While out_valid[i]=1 and out_ready[i]=0, out_data[i] is held stable (no overwrite).
//   - in_data and in_sel are ignored when in_valid=0.
//     - out_ready on an empty channel has no effect.
//   - pending is registered: it equals the popcount of out_valid after every edge.
//   - No combinational path from in_valid or in_data to any output; in_ready is the only
//     combinational output.
//
// TESTING
//   1. Reset: hold reset=0 for 2 cycles with in_valid=1, in_sel=1, in_data=16'h4567.
//      -> in_ready=0, out_valid=0000, all out_data=0, pending=0.
//   2. Single dispatch (WIDTH=16): in_sel=2, in_data=16'h89AB, out_ready=0000, 1 cycle.
//      -> next cycle out_valid=0100, out_data[2]=16'h89AB, pending=1.
//      -> held unchanged for 5 stalled cycles.
//   3. Backpressure: with ch2 full and out_ready[2]=0, present in_sel=2, in_data=16'hCDEF.
//      -> in_ready=0, no state change.
//      -> then out_ready[2]=1: accepted, out_valid[2] stays 1, out_data[2]=16'hCDEF.
//   4. Sweep: in_sel=0..3 with in_data 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF on
//      consecutive cycles, out_ready=0000.
//      -> out_valid=1111, pending=4, each channel holds its own word, in_ready=0 for every sel.
//   5. Drain and reset mid-operation: from state 4, out_ready=0101 for 1 cycle.
//      -> out_valid=1010, pending=2.
//      -> then reset=0 for 1 cycle: out_valid=0000, all out_data=0, pending=0.
//   6. Independent channels: ch3 full and stalled, in_sel=0 with in_data=16'h1111.
//      -> accepted immediately; out_valid=1001.

Source files
------------

// File: rtl/bus_demux1_4_reg.sv
// Registered 1-to-4 bus distributor: one valid/ready input word is steered by in_sel
// into one of four single-entry holding registers, each with its own valid/ready output.
module bus_demux1_4_reg #(
  parameter int WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_sel,
  input  logic [WIDTH-1:0]      in_data,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  output logic [3:0][WIDTH-1:0] out_data,
  output logic [2:0]            pending
);

  // Handshake: a word moves on any cycle where valid and ready are both high at the
  // rising edge; a producer holding valid keeps its data stable until it is taken.

  logic [3:0] load;
  logic [3:0] drain;
  logic [3:0] valid_nxt;
  logic [2:0] pending_nxt;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Only the selected channel can stall the input; a full channel that is draining
  // this cycle can be refilled without a bubble.
  always_comb begin
    in_ready    = reset & (~out_valid[in_sel] | out_ready[in_sel]);
    load        = 4'b0000;
    if (in_valid && in_ready) load = 4'b0001 << in_sel;
    drain       = out_valid & out_ready;
    valid_nxt   = (out_valid & ~drain) | load;
    pending_nxt = popcount4(valid_nxt);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 4'b0000;
      out_data  <= '0;
      pending   <= 3'd0;
    end else begin
      out_valid <= valid_nxt;
      pending   <= pending_nxt;
      for (int i = 0; i < 4; i++) begin
        if (load[i]) out_data[i] <= in_data;
      end
    end
  end

endmodule
